// File: rtl/hydra_pll_ctrl.sv
// hydra_pll_ctrl: sequences PLL reset and lock qualification, handles retries and
// fault, and applies feedback-delay changes through a controlled PLL re-reset.
module hydra_pll_ctrl #(
   parameter int unsigned RESET_CYCLES       = 16,
   parameter int unsigned LOCK_STABLE_CYCLES = 1024,
   parameter int unsigned LOCK_TIMEOUT       = 65535,
   parameter int unsigned MAX_RETRIES        = 3,
   parameter logic [7:0]  DELAY_INIT         = 8'h00
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       PLL_LOCK,
   input  logic       DELAY_REQ,
   input  logic [7:0] DELAY_VAL,
   output logic       DELAY_ACK,
   output logic       PLL_RESETB,
   output logic [7:0] PLL_DYNAMICDELAY,
   output logic       SYS_RESET,
   output logic       LOCKED,
   output logic       FAULT,
   output logic [3:0] RETRY_COUNT
);

   localparam int unsigned CNT_W   = 16;
   localparam int unsigned RETRY_W = 4;

   // Last counter value of each timed phase. The lock_s=1 cycle that moves
   // WAIT_LOCK into STABLE is the first of the consecutive stable cycles.
   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STB_LAST =
      CNT_W'((LOCK_STABLE_CYCLES >= 2) ? (LOCK_STABLE_CYCLES - 2) : 0);

   typedef enum logic [2:0] {
      S_RESET     = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_RUN       = 3'd3,
      S_FAULT     = 3'd4
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_lock_s1;
   logic                 r_lock_s;
   logic                 w_fail;
   logic                 w_accept;
   logic [RETRY_W-1:0]   w_retry_inc;
   logic                 w_to_fault;

   logic                 r_pll_resetb;
   logic                 r_sys_reset;
   logic                 r_locked;
   logic                 r_fault;
   logic                 r_ack;
   logic [7:0]           r_delay;
   logic [RETRY_W-1:0]   r_retry;

   logic                 w_pll_resetb_d;
   logic                 w_sys_reset_d;
   logic                 w_locked_d;
   logic                 w_fault_d;
   logic                 w_ack_d;
   logic [7:0]           w_delay_d;
   logic [RETRY_W-1:0]   w_retry_d;

   // Two-flop synchroniser for the asynchronous PLL lock indication
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_lock_s1 <= 1'b0;
         r_lock_s  <= 1'b0;
      end else begin
         r_lock_s1 <= PLL_LOCK;
         r_lock_s  <= r_lock_s1;
      end
   end

   // State register and shared phase counter, cleared on every state change
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state <= S_RESET;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if (w_next != r_state) begin
            r_cnt <= '0;
         end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   // Saturating retry increment and the fault decision for a failed attempt
   always_comb begin
      w_retry_inc = (r_retry == '1) ? r_retry : r_retry + RETRY_W'(1);
      w_to_fault  = (32'(w_retry_inc) >= 32'(MAX_RETRIES));
   end

   // Next-state decision; lock loss outranks a delay request in S_RUN
   always_comb begin
      w_next   = r_state;
      w_fail   = 1'b0;
      w_accept = 1'b0;
      case (r_state)
         S_RESET: begin
            if (r_cnt >= RST_LAST) w_next = S_WAIT_LOCK;
         end
         S_WAIT_LOCK: begin
            if (r_lock_s)               w_next = S_STABLE;
            else if (r_cnt >= TO_LAST)  w_fail = 1'b1;
         end
         S_STABLE: begin
            if (!r_lock_s)              w_next = S_WAIT_LOCK;
            else if (r_cnt >= STB_LAST) w_next = S_RUN;
         end
         S_RUN: begin
            if (!r_lock_s) begin
               w_fail = 1'b1;
            end else if (DELAY_REQ) begin
               w_accept = 1'b1;
               w_next   = S_RESET;
            end
         end
         S_FAULT: begin
            w_next = S_FAULT;
         end
         default: begin
            w_next = S_RESET;
         end
      endcase
      if (w_fail) w_next = w_to_fault ? S_FAULT : S_RESET;
   end

   // Output values for the upcoming state, so registered outputs track the state
   always_comb begin
      w_pll_resetb_d = !((w_next == S_RESET) || (w_next == S_FAULT));
      w_sys_reset_d  = (w_next != S_RUN);
      w_locked_d     = (w_next == S_RUN);
      w_fault_d      = (w_next == S_FAULT);
      w_ack_d        = w_accept;
      w_delay_d      = w_accept ? DELAY_VAL : r_delay;
      w_retry_d      = r_retry;
      if (w_fail) begin
         w_retry_d = w_retry_inc;
      end else if ((w_next == S_RUN) && (r_state != S_RUN)) begin
         w_retry_d = '0;
      end
   end

   // Output registers
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_pll_resetb <= 1'b0;
         r_sys_reset  <= 1'b1;
         r_locked     <= 1'b0;
         r_fault      <= 1'b0;
         r_ack        <= 1'b0;
         r_delay      <= DELAY_INIT;
         r_retry      <= '0;
      end else begin
         r_pll_resetb <= w_pll_resetb_d;
         r_sys_reset  <= w_sys_reset_d;
         r_locked     <= w_locked_d;
         r_fault      <= w_fault_d;
         r_ack        <= w_ack_d;
         r_delay      <= w_delay_d;
         r_retry      <= w_retry_d;
      end
   end

   assign PLL_RESETB       = r_pll_resetb;
   assign SYS_RESET        = r_sys_reset;
   assign LOCKED           = r_locked;
   assign FAULT            = r_fault;
   assign DELAY_ACK        = r_ack;
   assign PLL_DYNAMICDELAY = r_delay;
   assign RETRY_COUNT      = r_retry;

endmodule

// File: tb/tb_hydra_pll_ctrl.sv
// Bench for hydra_pll_ctrl: cycle model of the attempt/retry rules plus directed
// scenarios with hand-counted latencies.
module tb_hydra_pll_ctrl;

   localparam int unsigned RC  = 4;
   localparam int unsigned LSC = 8;
   localparam int unsigned LT  = 32;
   localparam int unsigned MR  = 3;
   localparam logic [7:0]  DINIT = 8'h3C;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       PLL_LOCK = 1'b0;
   logic       DELAY_REQ = 1'b0;
   logic [7:0] DELAY_VAL = 8'h00;
   logic       DELAY_ACK;
   logic       PLL_RESETB;
   logic [7:0] PLL_DYNAMICDELAY;
   logic       SYS_RESET;
   logic       LOCKED;
   logic       FAULT;
   logic [3:0] RETRY_COUNT;

   hydra_pll_ctrl #(
      .RESET_CYCLES(RC), .LOCK_STABLE_CYCLES(LSC), .LOCK_TIMEOUT(LT),
      .MAX_RETRIES(MR), .DELAY_INIT(DINIT)
   ) dut (
      .CLK(CLK), .RESET(RESET), .PLL_LOCK(PLL_LOCK), .DELAY_REQ(DELAY_REQ),
      .DELAY_VAL(DELAY_VAL), .DELAY_ACK(DELAY_ACK), .PLL_RESETB(PLL_RESETB),
      .PLL_DYNAMICDELAY(PLL_DYNAMICDELAY), .SYS_RESET(SYS_RESET), .LOCKED(LOCKED),
      .FAULT(FAULT), .RETRY_COUNT(RETRY_COUNT)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_err = 0;
   bit cmp_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: remaining PLL-reset hold cycles, cycles spent waiting for lock,
   // length of the current run of synced-lock cycles, plus status.
   typedef struct packed {
      int         hold;
      int         wt;
      int         run;
      int         retry;
      logic       running;
      logic       fault;
      logic       ack;
      logic [7:0] delay;
   } mdl_t;

   mdl_t m;
   logic m_s1, m_s2;

   function automatic mdl_t reset_model();
      mdl_t r;
      r.hold = RC; r.wt = 0; r.run = 0; r.retry = 0;
      r.running = 1'b0; r.fault = 1'b0; r.ack = 1'b0; r.delay = DINIT;
      return r;
   endfunction

   function automatic mdl_t step(input mdl_t c, input logic ls, input logic req,
                                 input logic [7:0] val);
      mdl_t n;
      bit fail;
      n = c;
      n.ack = 1'b0;
      fail = 1'b0;
      if (c.fault) begin
         n = c;
         n.ack = 1'b0;
      end else if (c.hold > 0) begin
         n.hold = c.hold - 1;
         if (n.hold == 0) begin n.wt = 0; n.run = 0; end
      end else if (c.running) begin
         if (!ls) fail = 1'b1;
         else if (req) begin
            n.delay = val; n.ack = 1'b1; n.running = 1'b0; n.hold = RC;
         end
      end else if (ls) begin
         n.run = c.run + 1;
         if (n.run == LSC) begin n.running = 1'b1; n.retry = 0; end
      end else if (c.run > 0) begin
         n.run = 0; n.wt = 0;
      end else begin
         n.wt = c.wt + 1;
         if (n.wt == LT) fail = 1'b1;
      end
      if (fail) begin
         n.running = 1'b0;
         n.retry = (c.retry < 15) ? c.retry + 1 : 15;
         if (n.retry >= MR) n.fault = 1'b1;
         else n.hold = RC;
      end
      return n;
   endfunction

   // Model update, including its own lock synchroniser
   always @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         m <= reset_model();
         m_s1 <= 1'b0;
         m_s2 <= 1'b0;
      end else begin
         m <= step(m, m_s2, DELAY_REQ, DELAY_VAL);
         m_s1 <= PLL_LOCK;
         m_s2 <= m_s1;
      end
   end

   // Per-cycle check of every output against the model
   always @(negedge CLK) begin
      if (cmp_en) begin
         chk("cyc_resetb", 32'(PLL_RESETB), 32'((m.hold == 0) && !m.fault));
         chk("cyc_sysrst", 32'(SYS_RESET), 32'(!m.running));
         chk("cyc_locked", 32'(LOCKED), 32'(m.running));
         chk("cyc_fault", 32'(FAULT), 32'(m.fault));
         chk("cyc_ack", 32'(DELAY_ACK), 32'(m.ack));
         chk("cyc_delay", 32'(PLL_DYNAMICDELAY), 32'(m.delay));
         chk("cyc_retry", 32'(RETRY_COUNT), 32'(m.retry));
      end
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge CLK); #1; end
   endtask

   function automatic logic [31:0] sig(input int sel);
      case (sel)
         0: return 32'(PLL_RESETB);
         1: return 32'(SYS_RESET);
         2: return 32'(RETRY_COUNT);
         default: return 32'(FAULT);
      endcase
   endfunction

   task automatic wait_sig(input int sel, input logic [31:0] val, input int budget,
                           input string name, output int n);
      n = 0;
      while (sig(sel) !== val && n < budget) begin tick(1); n++; end
      if (sig(sel) !== val) chk({name, "_timeout"}, sig(sel), val);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_resetb"}, 32'(PLL_RESETB), 32'd0);
      chk({tag, "_delay"}, 32'(PLL_DYNAMICDELAY), 32'h3C);
      chk({tag, "_sysrst"}, 32'(SYS_RESET), 32'd1);
      chk({tag, "_locked"}, 32'(LOCKED), 32'd0);
      chk({tag, "_fault"}, 32'(FAULT), 32'd0);
      chk({tag, "_ack"}, 32'(DELAY_ACK), 32'd0);
      chk({tag, "_retry"}, 32'(RETRY_COUNT), 32'd0);
   endtask

   initial begin
      int n;
      #12;
      chk_reset_vals("rst");
      cmp_en = 1'b1;
      tick(1);
      RESET = 1'b0;

      // Nominal: 4-cycle PLL reset, lock 10 cycles later, release 10 cycles after lock
      wait_sig(0, 1, 20, "nom_hold", n);
      chk("nom_hold_len", n, 4);
      tick(10);
      PLL_LOCK = 1'b1;
      wait_sig(1, 0, 40, "nom_rel", n);
      chk("nom_rel_lat", n, 10);
      chk("nom_locked", 32'(LOCKED), 1);
      chk("nom_retry", 32'(RETRY_COUNT), 0);

      // Delay change accepted in S_RUN
      tick(3);
      DELAY_VAL = 8'h5A;
      DELAY_REQ = 1'b1;
      tick(1);
      chk("dly_ack", 32'(DELAY_ACK), 1);
      chk("dly_val", 32'(PLL_DYNAMICDELAY), 32'h5A);
      chk("dly_sysrst", 32'(SYS_RESET), 1);
      chk("dly_resetb", 32'(PLL_RESETB), 0);
      DELAY_REQ = 1'b0;
      DELAY_VAL = 8'h00;
      tick(1);
      chk("dly_ack_pulse", 32'(DELAY_ACK), 0);
      wait_sig(0, 1, 20, "dly_hold", n);
      chk("dly_hold_len", n, 3);
      wait_sig(1, 0, 40, "dly_relock", n);
      chk("dly_relock_lat", n, 8);
      chk("dly_keep", 32'(PLL_DYNAMICDELAY), 32'h5A);
      chk("dly_retry", 32'(RETRY_COUNT), 0);

      // Collision: lock loss and request seen in the same S_RUN cycle
      tick(2);
      PLL_LOCK = 1'b0;
      tick(2);
      DELAY_VAL = 8'hA7;
      DELAY_REQ = 1'b1;
      tick(1);
      chk("col_ack", 32'(DELAY_ACK), 0);
      chk("col_retry", 32'(RETRY_COUNT), 1);
      chk("col_delay", 32'(PLL_DYNAMICDELAY), 32'h5A);
      PLL_LOCK = 1'b1;
      wait_sig(1, 0, 60, "col_rel", n);
      chk("col_retry_clr", 32'(RETRY_COUNT), 0);
      tick(1);
      chk("col_ack_late", 32'(DELAY_ACK), 1);
      chk("col_delay_late", 32'(PLL_DYNAMICDELAY), 32'hA7);
      DELAY_REQ = 1'b0;
      DELAY_VAL = 8'h00;

      // Async reset between edges while running
      wait_sig(1, 0, 60, "ar_rel", n);
      tick(2);
      #2 RESET = 1'b1;
      #1 chk_reset_vals("ar");

      // Glitch during STABLE restarts the qualification
      PLL_LOCK = 1'b0;
      tick(2);
      RESET = 1'b0;
      wait_sig(0, 1, 20, "gl_hold", n);
      PLL_LOCK = 1'b1;
      tick(5);
      PLL_LOCK = 1'b0;
      tick(1);
      PLL_LOCK = 1'b1;
      wait_sig(1, 0, 40, "gl_rel", n);
      chk("gl_rel_lat", n, 10);
      chk("gl_retry", 32'(RETRY_COUNT), 0);

      // Timeout: three 36-cycle attempts then fault
      RESET = 1'b1;
      PLL_LOCK = 1'b0;
      tick(2);
      RESET = 1'b0;
      wait_sig(2, 1, 60, "to_r1", n);
      chk("to_r1_lat", n, 36);
      wait_sig(2, 2, 60, "to_r2", n);
      chk("to_r2_lat", n, 36);
      wait_sig(3, 1, 60, "to_flt", n);
      chk("to_flt_lat", n, 36);
      chk("to_retry", 32'(RETRY_COUNT), 3);
      chk("to_resetb", 32'(PLL_RESETB), 0);
      chk("to_sysrst", 32'(SYS_RESET), 1);
      PLL_LOCK = 1'b1;
      DELAY_REQ = 1'b1;
      tick(20);
      chk("to_stuck", 32'(FAULT), 1);
      chk("to_noack", 32'(DELAY_ACK), 0);
      DELAY_REQ = 1'b0;
      #2 RESET = 1'b1;
      #1 chk_reset_vals("flt_rst");
      tick(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
